// File: rtl/ula_mc.sv
// ---------------------------------------------------------------------------
// ula_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle operations (add, sub, or, slt, sll, srl, and) are computed
// from the request inputs at the accept edge, so the result is presented
// with latency 1. The optional multiplier is an iterative shift-add unit
// that consumes one multiplier bit per cycle in the BUSY state.
//
// Configuration macro:
//   ULA_MUL_EN  defined   -> opcode 110 is an unsigned WIDTH x WIDTH multiply
//                            producing the low WIDTH bits (BUSY for WIDTH cycles)
//               undefined -> no multiplier hardware and no BUSY state; opcode
//                            110 completes at once with out = 0 and err = 1
//
// Parameters:
//   WIDTH      operand/result width in bits (8..64)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present on in1/in2/ctrl
//   in_ready   block accepts a request this cycle (only while idle)
//   in1        operand A
//   in2        operand B, or shift amount for shifts
//   ctrl       opcode: 000 add, 001 sub, 010 or, 011 slt,
//                      100 sll, 101 srl, 110 mul, 111 and
//   out_valid  out/flags hold a valid result
//   out_ready  consumer takes the result this cycle
//   out        registered result
//   flags      {err, neg, zero, ovf, carry}, registered with out
// ---------------------------------------------------------------------------
module ula_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [4:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;
`endif

    state_t state;

    // Single-cycle datapath signals
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             shift_big;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [4:0]       alu_flags;

    // Combinational result for every opcode that finishes in one cycle.
    // The extra top bit of sum/diff is the carry out / borrow. A shift
    // amount is the full unsigned value of in2, so anything >= WIDTH
    // flushes every bit out and yields zero.
    always_comb begin
        sum       = {1'b0, in1} + {1'b0, in2};
        diff      = {1'b0, in1} - {1'b0, in2};
        shift_big = (64'(in2) >= 64'(WIDTH));
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                            (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                            (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_OR: begin
                alu_res = in1 | in2;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            end
            OP_SLL: begin
                alu_res = shift_big ? '0 : (in1 << in2);
            end
            OP_SRL: begin
                alu_res = shift_big ? '0 : (in1 >> in2);
            end
            OP_MUL: begin
`ifdef ULA_MUL_EN
                // Handled by the iterative multiplier; this value is unused.
                alu_res = '0;
`else
                alu_res = '0;
                alu_err = 1'b1;
`endif
            end
            OP_AND: begin
                alu_res = in1 & in2;
            end
            default: begin
                alu_res = '0;
            end
        endcase
        alu_flags = {alu_err, alu_res[WIDTH-1], (alu_res == '0), alu_ovf, alu_carry};
    end

`ifdef ULA_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               mul_hi_nz;

    // One partial product per cycle: the multiplicand is pre-shifted to
    // the weight of the current multiplier bit, so the accumulator never
    // needs to shift.
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        mul_hi_nz = |acc_next[2*WIDTH-1:WIDTH];
    end
`endif

    // Control FSM with all outputs registered. in_ready mirrors "state is
    // IDLE" but is kept as its own flop so it comes straight off a register.
    // Requests are only sampled in IDLE, which is what makes the operands
    // immune to changes after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
`ifdef ULA_MUL_EN
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ULA_MUL_EN
                        if (ctrl == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, in1};
                            mplier <= in2;
                            acc    <= '0;
                            count  <= '0;
                            state  <= BUSY;
                        end else
`endif
                        begin
                            out       <= alu_res;
                            flags     <= alu_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifdef ULA_MUL_EN
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // The last partial product is folded in directly from
                    // acc_next so the result lands after exactly WIDTH cycles.
                    if (count == LAST_STEP) begin
                        out       <= acc_next[WIDTH-1:0];
                        flags     <= {1'b0, acc_next[WIDTH-1],
                                      (acc_next[WIDTH-1:0] == '0),
                                      mul_hi_nz, mul_hi_nz};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mc.sv
// ---------------------------------------------------------------------------
// tb_ula_mc -- self-checking bench for ula_mc (WIDTH = 16).
// Directed vector table, hand-written handshake/reset sequences, then
// random operations checked against an arithmetic reference model.
// Works with or without ULA_MUL_EN defined.
// ---------------------------------------------------------------------------
module tb_ula_mc;

    localparam int W = 16;

`ifdef ULA_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [4:0]   flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic [4:0]   exp_flags;
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];

    ula_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operand values.
    // Returns {flags, out}.
    function automatic logic [W+4:0] refModel(input logic [2:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint full = longint'(1) << W;
        longint half = full / 2;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint r    = 0;
        longint s    = 0;
        bit     c    = 1'b0;
        bit     v    = 1'b0;
        bit     e    = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = (r >= full); s = sa + sb; v = (s >= half) || (s < -half); end
            3'd1: begin r = ua - ub; c = (ua < ub);   s = sa - sb; v = (s >= half) || (s < -half); end
            3'd2: r = ua | ub;
            3'd3: r = (ua < ub) ? 1 : 0;
            3'd4: r = (ub >= W) ? 0 : (ua << ub);
            3'd5: r = (ub >= W) ? 0 : (ua >> ub);
            3'd6: begin
`ifdef ULA_MUL_EN
                r = ua * ub;
                c = (r >= full);
                v = c;
`else
                r = 0;
                e = 1'b1;
`endif
            end
            default: r = ua & ub;
        endcase
        r = r & (full - 1);
        return {e, (r >= half), (r == 0), v, c, W'(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, drop it right after the accept edge while
    // scrambling the inputs, and measure cycles until out_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] got_out, output logic [4:0] got_flags,
                                 output int lat);
        int waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("in_ready_before_request", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        ctrl     = op;
        in1      = a;
        in2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl     = 3'($urandom);
        in1      = W'($urandom);
        in2      = W'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got_out   = out;
        got_flags = flags;
    endtask

    // Hold the result for a while, then take it and confirm the block
    // returns to idle one cycle later.
    task automatic releaseResult(input int hold);
        for (int k = 0; k < hold; k++) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("out_valid_drop", 64'(out_valid), 64'(0));
        checkOutput("in_ready_return", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] got_out;
        logic [4:0]   got_flags;
        int           lat;
        logic [W+4:0] exp;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = 3'd0;
        in1       = '0;
        in2       = '0;

        // Directed vectors: {op, a, b, out, flags{err,neg,zero,ovf,carry}, latency}
        vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 1});
        vecs.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 1});
        vecs.push_back('{3'd5, 16'h8000, 16'd20,   16'h0000, 5'b00100, 1});
        vecs.push_back('{3'd4, 16'h0001, 16'd15,   16'h8000, 5'b01000, 1});
        vecs.push_back('{3'd5, 16'h8000, 16'd16,   16'h0000, 5'b00100, 1});
        vecs.push_back('{3'd5, 16'h8000, 16'd15,   16'h0001, 5'b00000, 1});
        vecs.push_back('{3'd2, 16'h00F0, 16'h0F0F, 16'h0FFF, 5'b00000, 1});
        vecs.push_back('{3'd7, 16'hF0F0, 16'h0F0F, 16'h0000, 5'b00100, 1});
        vecs.push_back('{3'd3, 16'h0003, 16'h0005, 16'h0001, 5'b00000, 1});
        vecs.push_back('{3'd3, 16'hFFFF, 16'h0001, 16'h0000, 5'b00100, 1});
        vecs.push_back('{3'd1, 16'h0001, 16'h0002, 16'hFFFF, 5'b01001, 1});
        vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1});
`ifdef ULA_MUL_EN
        vecs.push_back('{3'd6, 16'h0100, 16'h0100, 16'h0000, 5'b00111, W + 1});
        vecs.push_back('{3'd6, 16'h0003, 16'h0005, 16'h000F, 5'b00000, W + 1});
`else
        vecs.push_back('{3'd6, 16'h0100, 16'h0100, 16'h0000, 5'b10100, 1});
        vecs.push_back('{3'd6, 16'h0003, 16'h0005, 16'h0000, 5'b10100, 1});
`endif

        // Reset state, checked while reset is still asserted
        #2;
        checkOutput("reset_out", 64'(out), 64'(0));
        checkOutput("reset_flags", 64'(flags), 64'(0));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, got_out, got_flags, lat);
            checkOutput($sformatf("vec%0d_out", i), 64'(got_out), 64'(vecs[i].exp_out));
            checkOutput($sformatf("vec%0d_flags", i), 64'(got_flags), 64'(vecs[i].exp_flags));
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            releaseResult(i % 3);
        end

        // Result held while the consumer stalls
        applyStimulus(3'd0, 16'h1234, 16'h1111, got_out, got_flags, lat);
        checkOutput("hold_first_out", 64'(got_out), 64'(16'h2345));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_out", k), 64'(out), 64'(16'h2345));
            checkOutput($sformatf("hold%0d_flags", k), 64'(flags), 64'(0));
            checkOutput($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'(1));
            checkOutput($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'(0));
        end
        releaseResult(0);

        // Reset pulsed in the middle of a multiply (or of its DONE hold)
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = 3'd6;
        in1      = 16'h0100;
        in2      = 16'h0100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_out", 64'(out), 64'(0));
        checkOutput("midop_reset_flags", 64'(flags), 64'(0));
        checkOutput("midop_reset_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midop_in_ready_after_release", 64'(in_ready), 64'(1));
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("midop_no_result", 64'(seen), 64'(0));

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            if ((op == 3'd4 || op == 3'd5) && ($urandom_range(0, 3) != 0))
                b = W'($urandom_range(0, W + 4));
            else
                b = W'($urandom);
            exp = refModel(op, a, b);
            applyStimulus(op, a, b, got_out, got_flags, lat);
            checkOutput($sformatf("rnd%0d_op%0d_out", i, op), 64'(got_out), 64'(exp[W-1:0]));
            checkOutput($sformatf("rnd%0d_op%0d_flags", i, op), 64'(got_flags), 64'(exp[W+4:W]));
            checkOutput($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat),
                        64'((op == 3'd6) ? MUL_LAT : 1));
            releaseResult($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
